microseq_ctrl: RTL and testbench

- Parametrised microprogram sequencer. Successor to the fixed 8-bit-PC, three-opcode sequencer.
- Holds a writable microcode store and presents the decoded control fields of the current word to the Kalman datapath.
- Adds jumps, a hardware loop counter and a bounded call/return stack, plus a sticky error flag and an abort.
- Sits between the host/loader and the matrix datapath control inputs.

---
 rtl/microseq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_microseq_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/microseq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : microseq_ctrl
// Brief    : Microprogram sequencer with writable store, loop counter and
//            bounded call/return stack driving the Kalman datapath controls.
// Revision : 1.0  initial release
// ============================================================================
module microseq_ctrl #(
    parameter  int ADDR_W  = 8,
    parameter  int A_W     = 5,
    parameter  int B_W     = 5,
    parameter  int D_W     = 2,
    parameter  int E_W     = 2,
    parameter  int STK_D   = 4,
    localparam int INSTR_W = 3 + A_W + B_W + D_W + E_W + ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_addr,
    input  logic               continue_i,
    input  logic               abort,
    input  logic               rom_we,
    input  logic [ADDR_W-1:0]  rom_waddr,
    input  logic [INSTR_W-1:0] rom_wdata,
    output logic [2:0]         ctl_op,
    output logic [A_W-1:0]     ctl_a,
    output logic [B_W-1:0]     ctl_b,
    output logic [D_W-1:0]     ctl_d,
    output logic [E_W-1:0]     ctl_e,
    output logic               ctl_valid,
    output logic               ready,
    output logic               err,
    output logic [ADDR_W-1:0]  pc_dbg,
    output logic [ADDR_W-1:0]  cnt_dbg
);

    localparam int SP_W  = $clog2(STK_D + 1);
    localparam int STK_N = 2 ** SP_W;
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [2:0] OP_STEP  = 3'd0;
    localparam logic [2:0] OP_WAIT  = 3'd1;
    localparam logic [2:0] OP_HALT  = 3'd2;
    localparam logic [2:0] OP_JUMP  = 3'd3;
    localparam logic [2:0] OP_LDCNT = 3'd4;
    localparam logic [2:0] OP_LOOP  = 3'd5;
    localparam logic [2:0] OP_CALL  = 3'd6;
    localparam logic [2:0] OP_RET   = 3'd7;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_cnt;
    logic [SP_W-1:0]     r_sp;
    logic                r_err;
    logic [INSTR_W-1:0]  r_rom   [DEPTH];
    logic [ADDR_W-1:0]   r_stack [STK_N];

    logic [INSTR_W-1:0]  w_word;
    logic [ADDR_W-1:0]   w_imm;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic                w_stk_full;
    logic                w_stk_empty;
    logic                w_push;

    assign w_word      = r_rom[r_pc];
    assign ctl_op      = w_word[INSTR_W-1 -: 3];
    assign ctl_a       = w_word[INSTR_W-4 -: A_W];
    assign ctl_b       = w_word[INSTR_W-4-A_W -: B_W];
    assign ctl_d       = w_word[INSTR_W-4-A_W-B_W -: D_W];
    assign ctl_e       = w_word[INSTR_W-4-A_W-B_W-D_W -: E_W];
    assign w_imm       = w_word[ADDR_W-1:0];
    assign w_pc_inc    = r_pc + ADDR_W'(1);
    assign w_stk_full  = (r_sp == SP_W'(STK_D));
    assign w_stk_empty = (r_sp == '0);
    assign w_push      = (r_state == S_RUN) && !abort && (ctl_op == OP_CALL) && !w_stk_full;

    assign ctl_valid = (r_state == S_RUN);
    assign ready     = (r_state == S_IDLE);
    assign err       = r_err;
    assign pc_dbg    = r_pc;
    assign cnt_dbg   = r_cnt;

    // Store and stack are plain memories: no reset, written on the clock only.
    always_ff @(posedge clk) begin
        if (rom_we) begin
            r_rom[rom_waddr] <= rom_wdata;
        end
        if (w_push) begin
            r_stack[r_sp] <= w_pc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_cnt   <= '0;
            r_sp    <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_state <= S_RUN;
                        r_pc    <= start_addr;
                        r_sp    <= '0;
                        r_err   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_sp    <= '0;
                    end else begin
                        case (ctl_op)
                            OP_STEP:  r_pc <= w_pc_inc;
                            OP_WAIT:  if (continue_i) r_pc <= w_pc_inc;
                            OP_HALT:  r_state <= S_IDLE;
                            OP_JUMP:  r_pc <= w_imm;
                            OP_LDCNT: begin
                                r_cnt <= w_imm;
                                r_pc  <= w_pc_inc;
                            end
                            OP_LOOP: begin
                                if (r_cnt != '0) begin
                                    r_cnt <= r_cnt - ADDR_W'(1);
                                    r_pc  <= w_imm;
                                end else begin
                                    r_pc  <= w_pc_inc;
                                end
                            end
                            OP_CALL: begin
                                if (w_stk_full) begin
                                    r_err   <= 1'b1;
                                    r_state <= S_IDLE;
                                end else begin
                                    r_sp <= r_sp + SP_W'(1);
                                    r_pc <= w_imm;
                                end
                            end
                            default: begin
                                if (w_stk_empty) begin
                                    r_err   <= 1'b1;
                                    r_state <= S_IDLE;
                                end else begin
                                    r_sp <= r_sp - SP_W'(1);
                                    r_pc <= r_stack[r_sp - SP_W'(1)];
                                end
                            end
                        endcase
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_microseq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_microseq_ctrl
// Brief    : Directed self-checking bench for microseq_ctrl (STK_D = 2).
// Revision : 1.0  initial release
// ============================================================================
module tb_microseq_ctrl;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 25;

    localparam logic [2:0] OP_STEP  = 3'd0;
    localparam logic [2:0] OP_WAIT  = 3'd1;
    localparam logic [2:0] OP_HALT  = 3'd2;
    localparam logic [2:0] OP_LDCNT = 3'd4;
    localparam logic [2:0] OP_LOOP  = 3'd5;
    localparam logic [2:0] OP_CALL  = 3'd6;
    localparam logic [2:0] OP_RET   = 3'd7;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [ADDR_W-1:0]  start_addr;
    logic               continue_i;
    logic               abort;
    logic               rom_we;
    logic [ADDR_W-1:0]  rom_waddr;
    logic [INSTR_W-1:0] rom_wdata;
    logic [2:0]         ctl_op;
    logic [4:0]         ctl_a;
    logic [4:0]         ctl_b;
    logic [1:0]         ctl_d;
    logic [1:0]         ctl_e;
    logic               ctl_valid;
    logic               ready;
    logic               err;
    logic [ADDR_W-1:0]  pc_dbg;
    logic [ADDR_W-1:0]  cnt_dbg;

    int checks   = 0;
    int failures = 0;

    microseq_ctrl #(
        .ADDR_W (ADDR_W),
        .A_W    (5),
        .B_W    (5),
        .D_W    (2),
        .E_W    (2),
        .STK_D  (2)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .continue_i (continue_i),
        .abort      (abort),
        .rom_we     (rom_we),
        .rom_waddr  (rom_waddr),
        .rom_wdata  (rom_wdata),
        .ctl_op     (ctl_op),
        .ctl_a      (ctl_a),
        .ctl_b      (ctl_b),
        .ctl_d      (ctl_d),
        .ctl_e      (ctl_e),
        .ctl_valid  (ctl_valid),
        .ready      (ready),
        .err        (err),
        .pc_dbg     (pc_dbg),
        .cnt_dbg    (cnt_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [2:0] op, input logic [4:0] a,
                      input logic [4:0] b, input logic [1:0] d, input logic [1:0] e,
                      input logic [7:0] imm);
        rom_we    = 1'b1;
        rom_waddr = addr;
        rom_wdata = {op, a, b, d, e, imm};
        tick();
        rom_we    = 1'b0;
    endtask

    task automatic go(input logic [7:0] addr);
        start      = 1'b1;
        start_addr = addr;
        tick();
        start      = 1'b0;
    endtask

    initial begin
        logic [7:0] loop_pc  [8];
        logic [7:0] loop_cnt [8];
        logic [7:0] call_pc  [5];
        loop_pc  = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2, 8'd3};
        loop_cnt = '{8'd0, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0};
        call_pc  = '{8'd0, 8'd4, 8'd8, 8'd5, 8'd1};

        rst_n = 1'b0; start = 1'b0; start_addr = '0; continue_i = 1'b0;
        abort = 1'b0; rom_we = 1'b0; rom_waddr = '0; rom_wdata = '0;
        #3;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_valid", 32'(ctl_valid), 32'd0);
        chk("rst_pc", 32'(pc_dbg), 32'd0);
        chk("rst_cnt", 32'(cnt_dbg), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // WAIT stall then release
        wr(8'd0, OP_STEP, 5'd1, 5'd2, 2'd3, 2'd1, 8'd0);
        wr(8'd1, OP_WAIT, 5'd3, 5'd0, 2'd0, 2'd0, 8'd0);
        wr(8'd2, OP_STEP, 5'd5, 5'd0, 2'd0, 2'd0, 8'd0);
        wr(8'd3, OP_HALT, 5'd7, 5'd0, 2'd0, 2'd0, 8'd0);
        chk("idle_pc_hold", 32'(pc_dbg), 32'd0);
        go(8'd0);
        chk("w_valid", 32'(ctl_valid), 32'd1);
        chk("w_ready", 32'(ready), 32'd0);
        chk("w_pc0", 32'(pc_dbg), 32'd0);
        chk("w_a0", 32'(ctl_a), 32'd1);
        chk("w_b0", 32'(ctl_b), 32'd2);
        chk("w_d0", 32'(ctl_d), 32'd3);
        chk("w_e0", 32'(ctl_e), 32'd1);
        tick();
        chk("w_pc1", 32'(pc_dbg), 32'd1);
        chk("w_a1", 32'(ctl_a), 32'd3);
        chk("w_op1", 32'(ctl_op), 32'(OP_WAIT));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("w_stall", 32'(pc_dbg), 32'd1);
        end
        continue_i = 1'b1;
        tick();
        continue_i = 1'b0;
        chk("w_pc2", 32'(pc_dbg), 32'd2);
        chk("w_a2", 32'(ctl_a), 32'd5);
        tick();
        chk("w_pc3", 32'(pc_dbg), 32'd3);
        chk("w_a3", 32'(ctl_a), 32'd7);
        chk("w_notready", 32'(ready), 32'd0);
        tick();
        chk("h_ready", 32'(ready), 32'd1);
        chk("h_valid", 32'(ctl_valid), 32'd0);
        chk("h_pc", 32'(pc_dbg), 32'd3);

        // hardware loop
        wr(8'd0, OP_LDCNT, 5'd0, 5'd0, 2'd0, 2'd0, 8'd2);
        wr(8'd1, OP_STEP,  5'd0, 5'd0, 2'd0, 2'd0, 8'd0);
        wr(8'd2, OP_LOOP,  5'd0, 5'd0, 2'd0, 2'd0, 8'd1);
        wr(8'd3, OP_HALT,  5'd0, 5'd0, 2'd0, 2'd0, 8'd0);
        go(8'd0);
        for (int i = 0; i < 8; i++) begin
            chk("l_pc", 32'(pc_dbg), 32'(loop_pc[i]));
            chk("l_cnt", 32'(cnt_dbg), 32'(loop_cnt[i]));
            tick();
        end
        chk("l_ready", 32'(ready), 32'd1);
        chk("l_pc_end", 32'(pc_dbg), 32'd3);

        // call / return nesting, then overflow
        wr(8'd0, OP_CALL, 5'd0, 5'd0, 2'd0, 2'd0, 8'd4);
        wr(8'd4, OP_CALL, 5'd0, 5'd0, 2'd0, 2'd0, 8'd8);
        wr(8'd5, OP_RET,  5'd0, 5'd0, 2'd0, 2'd0, 8'd0);
        wr(8'd8, OP_RET,  5'd0, 5'd0, 2'd0, 2'd0, 8'd0);
        wr(8'd1, OP_HALT, 5'd0, 5'd0, 2'd0, 2'd0, 8'd0);
        go(8'd0);
        for (int i = 0; i < 5; i++) begin
            chk("c_pc", 32'(pc_dbg), 32'(call_pc[i]));
            tick();
        end
        chk("c_ready", 32'(ready), 32'd1);
        chk("c_err", 32'(err), 32'd0);
        chk("c_pc_end", 32'(pc_dbg), 32'd1);
        wr(8'd8, OP_CALL, 5'd0, 5'd0, 2'd0, 2'd0, 8'd12);
        go(8'd0);
        tick();
        tick();
        chk("o_pc8", 32'(pc_dbg), 32'd8);
        chk("o_err_pre", 32'(err), 32'd0);
        tick();
        chk("o_err", 32'(err), 32'd1);
        chk("o_ready", 32'(ready), 32'd1);
        chk("o_pc", 32'(pc_dbg), 32'd8);

        // RET on empty stack; err cleared by next start; abort beats CALL
        wr(8'd10, OP_RET, 5'd0, 5'd0, 2'd0, 2'd0, 8'd0);
        go(8'd10);
        chk("r_err_kept", 32'(err), 32'd0);
        tick();
        chk("r_err", 32'(err), 32'd1);
        chk("r_ready", 32'(ready), 32'd1);
        chk("r_pc", 32'(pc_dbg), 32'd10);
        go(8'd0);
        chk("r_err_clr", 32'(err), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("a_call_ready", 32'(ready), 32'd1);
        chk("a_call_pc", 32'(pc_dbg), 32'd0);
        chk("a_call_err", 32'(err), 32'd0);

        // abort while stalled at WAIT, start alongside abort ignored
        wr(8'd0, OP_STEP, 5'd0, 5'd0, 2'd0, 2'd0, 8'd0);
        wr(8'd1, OP_WAIT, 5'd0, 5'd0, 2'd0, 2'd0, 8'd0);
        go(8'd0);
        tick();
        tick();
        chk("a_stall", 32'(pc_dbg), 32'd1);
        abort = 1'b1; start = 1'b1; start_addr = 8'd5;
        tick();
        chk("a_ready", 32'(ready), 32'd1);
        chk("a_pc", 32'(pc_dbg), 32'd1);
        tick();
        chk("a_idle_ready", 32'(ready), 32'd1);
        chk("a_idle_pc", 32'(pc_dbg), 32'd1);
        abort = 1'b0; start = 1'b0;

        // PC wrap and CALL at top address pushes 0
        wr(8'd255, OP_CALL, 5'd0, 5'd0, 2'd0, 2'd0, 8'd20);
        wr(8'd20,  OP_RET,  5'd0, 5'd0, 2'd0, 2'd0, 8'd0);
        wr(8'd254, OP_STEP, 5'd0, 5'd0, 2'd0, 2'd0, 8'd0);
        go(8'd254);
        tick();
        chk("t_pc255", 32'(pc_dbg), 32'd255);
        tick();
        chk("t_pc20", 32'(pc_dbg), 32'd20);
        tick();
        chk("t_wrap", 32'(pc_dbg), 32'd0);
        chk("t_err", 32'(err), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // asynchronous reset mid-run
        wr(8'd0, OP_LDCNT, 5'd0, 5'd0, 2'd0, 2'd0, 8'd5);
        wr(8'd1, OP_STEP,  5'd0, 5'd0, 2'd0, 2'd0, 8'd0);
        wr(8'd2, OP_WAIT,  5'd0, 5'd0, 2'd0, 2'd0, 8'd0);
        go(8'd0);
        tick();
        tick();
        tick();
        chk("x_pc", 32'(pc_dbg), 32'd2);
        chk("x_cnt", 32'(cnt_dbg), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("x_ready", 32'(ready), 32'd1);
        chk("x_valid", 32'(ctl_valid), 32'd0);
        chk("x_pc0", 32'(pc_dbg), 32'd0);
        chk("x_cnt0", 32'(cnt_dbg), 32'd0);
        chk("x_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
